// File: rtl/alu_instr_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: widths, state
// encoding, instruction field positions and the logic opcodes that the ALU
// and its bench share.
package alu_instr_sequencer_pkg;

  localparam int DATA_W  = 4;
  localparam int NREG    = 4;
  localparam int SEL_W   = $clog2(NREG);
  localparam int OP_W    = 3;
  localparam int INSTR_W = 14;

  // Instruction word layout: [13] ld, [12:10] op, [9:8] rd, [7:6] rs1,
  // [5:4] rs2, [3:0] imm.
  localparam int LD_BIT  = 13;
  localparam int OP_LSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic              ld;
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  rd;
    logic [SEL_W-1:0]  rs1;
    logic [SEL_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Write-back context kept across EXEC/WB; operands and opcode are already
  // latched into the ALU drive registers at accept time.
  typedef struct packed {
    logic              ld;
    logic [SEL_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
  } wb_ctx_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.ld  = w[LD_BIT];
    d.op  = w[OP_LSB  +: OP_W];
    d.rd  = w[RD_LSB  +: SEL_W];
    d.rs1 = w[RS1_LSB +: SEL_W];
    d.rs2 = w[RS2_LSB +: SEL_W];
    d.imm = w[IMM_LSB +: DATA_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Bus between the instruction producer / ALU / debug side (master) and the
// sequencer (slave).
//   instr_valid/instr_ready/instr : instruction handshake
//   alu_a/alu_b/alu_opcode        : ALU drive
//   alu_result/alu_zero/alu_overflow : ALU response
//   done/zero_flag/ovf_flag       : retire status
//   dbg_sel/dbg_data              : register-file debug read
interface alu_instr_sequencer_if;
  import alu_instr_sequencer_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_opcode;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                alu_overflow;
  logic                done;
  logic                zero_flag;
  logic                ovf_flag;
  logic [SEL_W-1:0]    dbg_sel;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output instr_valid, instr, alu_result, alu_zero, alu_overflow, dbg_sel,
    input  instr_ready, alu_a, alu_b, alu_opcode, done, zero_flag, ovf_flag,
           dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero, alu_overflow, dbg_sel,
    output instr_ready, alu_a, alu_b, alu_opcode, done, zero_flag, ovf_flag,
           dbg_data
  );
endinterface

// File: rtl/seq_regfile.sv
// NREG x DATA_W register file: one synchronous write port, two
// combinational operand read ports and a combinational debug read port.
//   clk, rst_n      : clock, async active-low reset (clears all entries)
//   we/waddr/wdata  : write port
//   raddr1/rdata1   : operand read port 1
//   raddr2/rdata2   : operand read port 2
//   dbg_sel/dbg_data: debug read port
module seq_regfile #(
  parameter  int DATA_W = 4,
  parameter  int NREG   = 4,
  localparam int SEL_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SEL_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [SEL_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned
    // (which would infer a latch).
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // NOTE: this array is flops, not SRAM, so it takes the async reset like
  // any other state; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking for all sequential state so every flop samples
      // pre-edge values regardless of statement order.
      regs_q <= regs_d;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control stage in front of the 4-bit ALU. Accepts one instruction at a time
// over valid/ready, drives ALU operands from its register file, and writes
// back either the ALU result (with flags) or a load immediate.
//   clk, rst_n : clock, async active-low reset
//   bus        : handshake, ALU drive/response, retire status, debug port
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  alu_instr_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  wb_ctx_t           ir_q, ir_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_zero_q, res_zero_d;
  logic              res_ovf_q, res_ovf_d;
  logic              zero_flag_q, zero_flag_d;
  logic              ovf_flag_q, ovf_flag_d;

  instr_t            instr_w;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

  assign instr_w = decode(bus.instr);

  // Operand ports read straight from the incoming word so the operands can be
  // registered on the accept edge and be stable for the whole EXEC cycle.
  seq_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (ir_q.rd),
    .wdata    (rf_wdata),
    .raddr1   (instr_w.rs1),
    .rdata1   (rf_rdata1),
    .raddr2   (instr_w.rs2),
    .rdata2   (rf_rdata2),
    .dbg_sel  (bus.dbg_sel),
    .dbg_data (bus.dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_d       = res_q;
    res_zero_d  = res_zero_q;
    res_ovf_d   = res_ovf_q;
    zero_flag_d = zero_flag_q;
    ovf_flag_d  = ovf_flag_q;
    rf_we       = 1'b0;
    rf_wdata    = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d = '{ld: instr_w.ld, rd: instr_w.rd, imm: instr_w.imm};
          if (instr_w.ld) begin
            state_d = WB;
          end else begin
            state_d  = EXEC;
            alu_a_d  = rf_rdata1;
            alu_b_d  = rf_rdata2;
            alu_op_d = instr_w.op;
          end
        end
      end
      EXEC: begin
        res_d      = bus.alu_result;
        res_zero_d = bus.alu_zero;
        res_ovf_d  = bus.alu_overflow;
        state_d    = WB;
      end
      WB: begin
        rf_we = 1'b1;
        if (ir_q.ld) begin
          rf_wdata    = ir_q.imm;
          zero_flag_d = (ir_q.imm == '0);
          ovf_flag_d  = 1'b0;
        end else begin
          zero_flag_d = res_zero_q;
          ovf_flag_d  = res_ovf_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_q       <= '0;
      res_zero_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      zero_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_q       <= res_d;
      res_zero_q  <= res_zero_d;
      res_ovf_q   <= res_ovf_d;
      zero_flag_q <= zero_flag_d;
      ovf_flag_q  <= ovf_flag_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.done        = (state_q == WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.zero_flag   = zero_flag_q;
  assign bus.ovf_flag    = ovf_flag_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;
  import alu_instr_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_instr_sequencer_if bus();

  alu_instr_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: ADD/SUB with signed overflow, AND/OR/XOR, others give 0.
  logic [3:0] m_res;
  logic       m_ovf;
  always_comb begin
    m_res = '0;
    m_ovf = 1'b0;
    case (bus.alu_opcode)
      3'b000: begin
        m_res = bus.alu_a + bus.alu_b;
        m_ovf = (bus.alu_a[3] == bus.alu_b[3]) && (m_res[3] != bus.alu_a[3]);
      end
      3'b001: begin
        m_res = bus.alu_a - bus.alu_b;
        m_ovf = (bus.alu_a[3] != bus.alu_b[3]) && (m_res[3] != bus.alu_a[3]);
      end
      OP_AND:  m_res = bus.alu_a & bus.alu_b;
      OP_OR:   m_res = bus.alu_a | bus.alu_b;
      OP_XOR:  m_res = bus.alu_a ^ bus.alu_b;
      default: m_res = '0;
    endcase
  end
  assign bus.alu_result   = m_res;
  assign bus.alu_zero     = (m_res == 4'h0);
  assign bus.alu_overflow = m_ovf;

  function automatic logic [13:0] mk(input logic ld, input logic [2:0] op,
                                     input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [1:0] rs2, input logic [3:0] imm);
    return {ld, op, rd, rs1, rs2, imm};
  endfunction

  task automatic read_reg(input logic [1:0] sel, output logic [3:0] val);
    bus.dbg_sel = sel;
    #1;
    val = bus.dbg_data;
  endtask

  // Issue one instruction from IDLE. lat = edges from accept to the edge at
  // which done is sampled high (-1 if it never comes). ea/eb/eop are the ALU
  // drive values seen in the cycle after accept. Returns one edge after WB.
  task automatic send_instr(input logic [13:0] w, output int lat,
                            output logic [3:0] ea, output logic [3:0] eb,
                            output logic [2:0] eop);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    ea  = bus.alu_a;
    eb  = bus.alu_b;
    eop = bus.alu_opcode;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instr_ready); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.zero_flag !== 1'b0 || bus.ovf_flag !== 1'b0)
      $display("FAIL reset_flags: got z=%b o=%b want 0 0", bus.zero_flag, bus.ovf_flag); else n_pass++;
    n_total++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 11'h0)
      $display("FAIL reset_alu_drive: got a=%h b=%h op=%b want 0", bus.alu_a, bus.alu_b, bus.alu_opcode); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      n_total++; if (v !== 4'h0) $display("FAIL reset_reg%0d: got %h want 0", i, v); else n_pass++;
    end
  endtask

  task automatic test_load();
    int lat; logic [3:0] a, b, v; logic [2:0] op;
    send_instr(mk(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'b1101), lat, a, b, op);
    n_total++; if (lat !== 1) $display("FAIL ld_r0_latency: got %0d want 1", lat); else n_pass++;
    send_instr(mk(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 4'b0011), lat, a, b, op);
    n_total++; if (lat !== 1) $display("FAIL ld_r1_latency: got %0d want 1", lat); else n_pass++;
    read_reg(2'd0, v);
    n_total++; if (v !== 4'b1101) $display("FAIL ld_r0_value: got %b want 1101", v); else n_pass++;
    read_reg(2'd1, v);
    n_total++; if (v !== 4'b0011) $display("FAIL ld_r1_value: got %b want 0011", v); else n_pass++;
    n_total++; if (bus.zero_flag !== 1'b0 || bus.ovf_flag !== 1'b0)
      $display("FAIL ld_flags: got z=%b o=%b want 0 0", bus.zero_flag, bus.ovf_flag); else n_pass++;
  endtask

  task automatic test_alu_and();
    int lat; logic [3:0] a, b, v; logic [2:0] op;
    send_instr(mk(1'b0, OP_AND, 2'd2, 2'd0, 2'd1, 4'h0), lat, a, b, op);
    n_total++; if (a !== 4'b1101 || b !== 4'b0011 || op !== OP_AND)
      $display("FAIL and_exec_drive: got a=%b b=%b op=%b want 1101 0011 100", a, b, op); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL and_latency: got %0d want 2", lat); else n_pass++;
    read_reg(2'd2, v);
    n_total++; if (v !== 4'b0001) $display("FAIL and_r2: got %b want 0001", v); else n_pass++;
    n_total++; if (bus.zero_flag !== 1'b0 || bus.ovf_flag !== 1'b0)
      $display("FAIL and_flags: got z=%b o=%b want 0 0", bus.zero_flag, bus.ovf_flag); else n_pass++;
    n_total++; if (bus.alu_a !== 4'b1101 || bus.alu_opcode !== OP_AND)
      $display("FAIL and_drive_hold: got a=%b op=%b want 1101 100", bus.alu_a, bus.alu_opcode); else n_pass++;
  endtask

  task automatic test_xor_or();
    int lat; logic [3:0] a, b, v; logic [2:0] op;
    send_instr(mk(1'b0, OP_XOR, 2'd3, 2'd0, 2'd0, 4'h0), lat, a, b, op);
    read_reg(2'd3, v);
    n_total++; if (v !== 4'b0000) $display("FAIL xor_r3: got %b want 0000", v); else n_pass++;
    n_total++; if (bus.zero_flag !== 1'b1) $display("FAIL xor_zero: got %b want 1", bus.zero_flag); else n_pass++;
    send_instr(mk(1'b0, OP_OR, 2'd3, 2'd0, 2'd1, 4'h0), lat, a, b, op);
    read_reg(2'd3, v);
    n_total++; if (v !== 4'b1111) $display("FAIL or_r3: got %b want 1111", v); else n_pass++;
    n_total++; if (bus.zero_flag !== 1'b0) $display("FAIL or_zero: got %b want 0", bus.zero_flag); else n_pass++;
    send_instr(mk(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 4'h0), lat, a, b, op);
    n_total++; if (bus.zero_flag !== 1'b1) $display("FAIL ld_imm0_zero: got %b want 1", bus.zero_flag); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones; logic [3:0] v;
    dones = 0;
    bus.instr       = mk(1'b0, OP_OR, 2'd2, 2'd0, 2'd1, 4'h0);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;                       // accepted -> EXEC
    bus.instr = mk(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 4'b0101);
    if (bus.done === 1'b1) dones++;
    n_total++; if (bus.instr_ready !== 1'b0) $display("FAIL b2b_ready_exec: got %b want 0", bus.instr_ready); else n_pass++;
    @(posedge clk); #1;                       // WB of first
    if (bus.done === 1'b1) dones++;
    n_total++; if (bus.instr_ready !== 1'b0) $display("FAIL b2b_ready_wb: got %b want 0", bus.instr_ready); else n_pass++;
    @(posedge clk); #1;                       // IDLE, second waiting
    if (bus.done === 1'b1) dones++;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", bus.instr_ready); else n_pass++;
    n_total++; if (dones !== 1) $display("FAIL b2b_first_done: got %0d dones want 1", dones); else n_pass++;
    @(posedge clk); #1;                       // second accepted -> WB
    bus.instr_valid = 1'b0;
    if (bus.done === 1'b1) dones++;
    @(posedge clk); #1;
    if (bus.done === 1'b1) dones++;
    @(posedge clk); #1;
    if (bus.done === 1'b1) dones++;
    n_total++; if (dones !== 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else n_pass++;
    read_reg(2'd2, v);
    n_total++; if (v !== 4'b1111) $display("FAIL b2b_r2: got %b want 1111", v); else n_pass++;
    read_reg(2'd3, v);
    n_total++; if (v !== 4'b0101) $display("FAIL b2b_r3: got %b want 0101", v); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat; logic [3:0] a, b, v; logic [2:0] op;
    send_instr(mk(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 4'b0111), lat, a, b, op);
    send_instr(mk(1'b0, 3'b000, 2'd3, 2'd2, 2'd1, 4'h0), lat, a, b, op);  // 7+3
    read_reg(2'd3, v);
    n_total++; if (v !== 4'b1010) $display("FAIL add_r3: got %b want 1010", v); else n_pass++;
    n_total++; if (bus.ovf_flag !== 1'b1 || bus.zero_flag !== 1'b0)
      $display("FAIL add_flags: got z=%b o=%b want 0 1", bus.zero_flag, bus.ovf_flag); else n_pass++;
    send_instr(mk(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 4'b0110), lat, a, b, op);
    read_reg(2'd3, v);
    n_total++; if (v !== 4'b0110) $display("FAIL ld_after_ovf_r3: got %b want 0110", v); else n_pass++;
    n_total++; if (bus.ovf_flag !== 1'b0) $display("FAIL ld_clears_ovf: got %b want 0", bus.ovf_flag); else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    int lat, dones; logic [3:0] a, b, v; logic [2:0] op;
    send_instr(mk(1'b0, 3'b000, 2'd3, 2'd2, 2'd1, 4'h0), lat, a, b, op);
    n_total++; if (bus.ovf_flag !== 1'b1) $display("FAIL pre_reset_ovf: got %b want 1", bus.ovf_flag); else n_pass++;
    bus.instr       = mk(1'b0, OP_AND, 2'd2, 2'd0, 2'd1, 4'h0);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    n_total++; if (bus.alu_a !== 4'b1101 || bus.alu_opcode !== OP_AND)
      $display("FAIL mid_exec_drive: got a=%b op=%b want 1101 100", bus.alu_a, bus.alu_opcode); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({bus.done, bus.zero_flag, bus.ovf_flag} !== 3'b000)
      $display("FAIL mid_rst_status: got done=%b z=%b o=%b want 0 0 0", bus.done, bus.zero_flag, bus.ovf_flag); else n_pass++;
    n_total++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 11'h0)
      $display("FAIL mid_rst_alu_drive: got a=%h b=%h op=%b want 0", bus.alu_a, bus.alu_b, bus.alu_opcode); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      n_total++; if (v !== 4'h0) $display("FAIL mid_rst_reg%0d: got %h want 0", i, v); else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", bus.instr_ready); else n_pass++;
    n_total++; if (dones !== 0) $display("FAIL post_rst_no_done: got %0d dones want 0", dones); else n_pass++;
    read_reg(2'd2, v);
    n_total++; if (v !== 4'h0) $display("FAIL post_rst_r2: got %h want 0", v); else n_pass++;
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_sel     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_alu_and();
    test_xor_or();
    test_back_to_back();
    test_overflow();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
